// File: rtl/dlist_fetch.sv
// dlist_fetch: ANTIC display-list DMA front end. Owns the display-list counter,
// fetches instruction/operand bytes on request from the mode translator, and
// assembles jump targets and memory-scan addresses from the fetched bytes.
module dlist_fetch #(
  parameter int WRAP_BITS = 10
) (
  input  logic        Fphi0,
  input  logic        RST,
  input  logic        dma_en,
  input  logic        cpu_wrL,
  input  logic        cpu_wrH,
  input  logic [7:0]  cpu_data,
  input  logic        loadIR,
  input  logic        loadDLISTL,
  input  logic        loadDLISTH,
  input  logic        loadMSRL,
  input  logic        loadMSRH,
  input  logic        DLISTjump,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        halt,
  output logic [7:0]  IR,
  output logic        IR_rdy,
  output logic [15:0] MSR,
  output logic [15:0] dlist_ptr,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  typedef enum logic [2:0] {D_IR, D_JL, D_JH, D_ML, D_MH} dest_t;

  state_t      state_q, state_d;
  dest_t       cur_dest_q, cur_dest_d;
  dest_t       pend_dest_q, pend_dest_d;
  logic        pend_v_q, pend_v_d;
  logic        ovr_q, ovr_d;
  logic [4:0]  ld_prev_q;
  logic        jprev_q;
  logic        jpend_q, jpend_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] jmp_q;
  logic [15:0] msr_q;
  logic [7:0]  ir_q;

  logic [4:0]  loads;
  logic [4:0]  rise;
  logic        trig;
  dest_t       trig_dest;
  logic        cap;
  logic        jump_req;

  // Only the low WRAP_BITS count; the upper bits pin the list to its 1K page.
  function automatic logic [15:0] wrap_inc(input logic [15:0] p);
    logic [WRAP_BITS-1:0] lo;
    lo = p[WRAP_BITS-1:0] + {{(WRAP_BITS-1){1'b0}}, 1'b1};
    return {p[15:WRAP_BITS], lo};
  endfunction

  assign loads    = {loadMSRH, loadMSRL, loadDLISTH, loadDLISTL, loadIR};
  assign rise     = loads & ~ld_prev_q;
  assign cap      = (state_q == S_REQ) && mem_ack;
  assign jump_req = (DLISTjump & ~jprev_q) | jpend_q;

  // Collapse simultaneous load edges into one trigger, operand loads first.
  always_comb begin
    trig      = 1'b1;
    trig_dest = D_IR;
    if (rise[1])      trig_dest = D_JL;
    else if (rise[2]) trig_dest = D_JH;
    else if (rise[3]) trig_dest = D_ML;
    else if (rise[4]) trig_dest = D_MH;
    else if (rise[0]) trig_dest = D_IR;
    else              trig      = 1'b0;
  end

  // Fetch sequencing plus the single-entry trigger queue and overrun flag.
  always_comb begin
    logic taken;
    logic deq;
    state_d     = state_q;
    cur_dest_d  = cur_dest_q;
    pend_v_d    = pend_v_q;
    pend_dest_d = pend_dest_q;
    ovr_d       = ovr_q;
    taken       = 1'b0;
    deq         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dma_en && pend_v_q) begin
          state_d    = S_REQ;
          cur_dest_d = pend_dest_q;
          deq        = 1'b1;
        end else if (dma_en && trig) begin
          state_d    = S_REQ;
          cur_dest_d = trig_dest;
          taken      = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        if (dma_en && pend_v_q) begin
          state_d    = S_REQ;
          cur_dest_d = pend_dest_q;
          deq        = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (deq) pend_v_d = 1'b0;
    // A slot freed by this cycle's dequeue may be refilled at once.
    if (trig && !taken) begin
      if (!pend_v_q || deq) begin
        pend_v_d    = 1'b1;
        pend_dest_d = trig_dest;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Counter next value: ack increment, then deferred jump, then CPU write on top.
  always_comb begin
    ptr_d   = ptr_q;
    jpend_d = jpend_q;
    if (cap) ptr_d = wrap_inc(ptr_q);
    if (jump_req) begin
      if (state_q != S_REQ) begin
        ptr_d   = jmp_q;
        jpend_d = 1'b0;
      end else begin
        jpend_d = 1'b1;
      end
    end
    if (cpu_wrL || cpu_wrH) begin
      ptr_d = ptr_q;
      if (cpu_wrL) ptr_d[7:0]  = cpu_data;
      if (cpu_wrH) ptr_d[15:8] = cpu_data;
    end
  end

  // Control state registers and edge-detect history.
  always_ff @(posedge Fphi0 or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      cur_dest_q  <= D_IR;
      pend_dest_q <= D_IR;
      pend_v_q    <= 1'b0;
      ovr_q       <= 1'b0;
      ld_prev_q   <= '0;
      jprev_q     <= 1'b0;
      jpend_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_dest_q  <= cur_dest_d;
      pend_dest_q <= pend_dest_d;
      pend_v_q    <= pend_v_d;
      ovr_q       <= ovr_d;
      ld_prev_q   <= loads;
      jprev_q     <= DLISTjump;
      jpend_q     <= jpend_d;
    end
  end

  // Datapath registers: counter and the byte steered by the latched destination.
  always_ff @(posedge Fphi0 or negedge RST) begin
    if (!RST) begin
      ptr_q <= '0;
      jmp_q <= '0;
      msr_q <= '0;
      ir_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (cap) begin
        ir_q <= mem_data;
        case (cur_dest_q)
          D_JL:    jmp_q[7:0]  <= mem_data;
          D_JH:    jmp_q[15:8] <= mem_data;
          D_ML:    msr_q[7:0]  <= mem_data;
          D_MH:    msr_q[15:8] <= mem_data;
          default: ;
        endcase
      end
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_addr  = mem_req ? ptr_q : 16'h0000;
  assign halt      = mem_req;
  assign IR        = ir_q;
  assign IR_rdy    = (state_q == S_DONE);
  assign MSR       = msr_q;
  assign dlist_ptr = ptr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_dlist_fetch.sv
// Bench for dlist_fetch: directed table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_dlist_fetch;

  logic        clk;
  logic        rst_n;
  logic        d_dma, d_wrl, d_wrh, d_ack, d_jmp;
  logic [7:0]  d_cd, d_dat;
  logic [4:0]  d_ld;
  logic        mem_req, halt, IR_rdy, overrun;
  logic [15:0] mem_addr, MSR, dlist_ptr;
  logic [7:0]  IR;

  int nvec  = 0;
  int nfail = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  localparam logic [4:0] L_IR = 5'b00001;
  localparam logic [4:0] L_JL = 5'b00010;
  localparam logic [4:0] L_JH = 5'b00100;
  localparam logic [4:0] L_ML = 5'b01000;
  localparam logic [4:0] L_MH = 5'b10000;

  dlist_fetch #(.WRAP_BITS(10)) dut (
    .Fphi0(clk), .RST(rst_n), .dma_en(d_dma),
    .cpu_wrL(d_wrl), .cpu_wrH(d_wrh), .cpu_data(d_cd),
    .loadIR(d_ld[0]), .loadDLISTL(d_ld[1]), .loadDLISTH(d_ld[2]),
    .loadMSRL(d_ld[3]), .loadMSRH(d_ld[4]), .DLISTjump(d_jmp),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(d_ack), .mem_data(d_dat),
    .halt(halt), .IR(IR), .IR_rdy(IR_rdy), .MSR(MSR),
    .dlist_ptr(dlist_ptr), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req && !req_prev) req_rises <= req_rises + 1;
    req_prev <= mem_req;
  end

  typedef struct {
    logic [4:0]  ld;
    logic        dma, ack;
    logic [7:0]  dat;
    logic        wrl, wrh;
    logic [7:0]  cd;
    logic        jmp;
    logic        ereq;
    logic [15:0] eaddr;
    logic [7:0]  eir;
    logic        erdy;
    logic [15:0] emsr, eptr;
    logic        eovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic [4:0] ld, logic dma, logic ack, logic [7:0] dat,
                               logic wrl, logic wrh, logic [7:0] cd, logic jmp,
                               logic ereq, logic [15:0] eaddr, logic [7:0] eir, logic erdy,
                               logic [15:0] emsr, logic [15:0] eptr, logic eovr);
    vec_t v;
    v.ld = ld; v.dma = dma; v.ack = ack; v.dat = dat; v.wrl = wrl; v.wrh = wrh;
    v.cd = cd; v.jmp = jmp; v.ereq = ereq; v.eaddr = eaddr; v.eir = eir;
    v.erdy = erdy; v.emsr = emsr; v.eptr = eptr; v.eovr = eovr;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [4:0] ld, logic dma, logic ack, logic [7:0] dat,
                       logic wrl, logic wrh, logic [7:0] cd, logic jmp);
    d_ld = ld; d_dma = dma; d_ack = ack; d_dat = dat;
    d_wrl = wrl; d_wrh = wrh; d_cd = cd; d_jmp = jmp;
  endtask

  task automatic check_all(string nm, logic ereq, logic [15:0] eaddr, logic [7:0] eir,
                           logic erdy, logic [15:0] emsr, logic [15:0] eptr, logic eovr);
    logic [59:0] act, exp;
    act = {mem_req, halt, mem_addr, IR, IR_rdy, MSR, dlist_ptr, overrun};
    exp = {ereq, ereq, eaddr, eir, erdy, emsr, eptr, eovr};
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got req=%b halt=%b addr=%h ir=%h rdy=%b msr=%h ptr=%h ovr=%b; want req=%b addr=%h ir=%h rdy=%b msr=%h ptr=%h ovr=%b",
               nm, mem_req, halt, mem_addr, IR, IR_rdy, MSR, dlist_ptr, overrun,
               ereq, eaddr, eir, erdy, emsr, eptr, eovr);
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_busy, m_rdy, m_ovr, m_jpend, m_prev_j;
  int          m_cur;
  int          mq[$];
  logic [15:0] m_ptr, m_jmp, m_msr;
  logic [7:0]  m_ir;
  logic [4:0]  m_prev_ld;

  task automatic model_reset();
    m_busy = 0; m_rdy = 0; m_ovr = 0; m_jpend = 0; m_prev_j = 0; m_cur = 0;
    mq.delete();
    m_ptr = 0; m_jmp = 0; m_msr = 0; m_ir = 0; m_prev_ld = 0;
  endtask

  // One clock of behaviour: 0=IR 1=JL 2=JH 3=ML 4=MH.
  task automatic model_step(logic [4:0] ld, logic dma, logic ack, logic [7:0] dat,
                            logic wrl, logic wrh, logic [7:0] cd, logic jmp);
    logic [4:0]  r;
    int          td;
    logic        was_busy, was_rdy;
    logic [15:0] np, old_jmp;
    r = ld & ~m_prev_ld;
    td = -1;
    if (r[1]) td = 1;
    else if (r[2]) td = 2;
    else if (r[3]) td = 3;
    else if (r[4]) td = 4;
    else if (r[0]) td = 0;
    was_busy = m_busy;
    was_rdy  = m_rdy;
    old_jmp  = m_jmp;
    np = m_ptr;
    m_rdy = 0;
    if (was_busy) begin
      if (ack) begin
        m_ir = dat;
        case (m_cur)
          1: m_jmp[7:0]  = dat;
          2: m_jmp[15:8] = dat;
          3: m_msr[7:0]  = dat;
          4: m_msr[15:8] = dat;
          default: ;
        endcase
        np = (m_ptr & 16'hFC00) | ((m_ptr + 16'd1) & 16'h03FF);
        m_busy = 0;
        m_rdy  = 1;
      end
    end else if (dma && mq.size() > 0) begin
      m_cur = mq.pop_front();
      m_busy = 1;
    end else if (dma && !was_rdy && td >= 0) begin
      m_cur = td;
      m_busy = 1;
      td = -1;
    end
    if (td >= 0) begin
      if (mq.size() == 0) mq.push_back(td);
      else m_ovr = 1;
    end
    if ((jmp && !m_prev_j) || m_jpend) begin
      if (!was_busy) begin np = old_jmp; m_jpend = 0; end
      else m_jpend = 1;
    end
    if (wrl || wrh) begin
      np = m_ptr;
      if (wrl) np[7:0]  = cd;
      if (wrh) np[15:8] = cd;
    end
    m_ptr = np;
    m_prev_ld = ld;
    m_prev_j  = jmp;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);

    // Directed table: first fetch, 1K wrap, jump assembly, MSR assembly.
    //              ld   dma ack dat    wrl wrh cd    jmp  req addr     ir     rdy msr      ptr      ovr
    tbl.push_back(mkv(0,    0, 0, 8'h00, 0, 1, 8'h20, 0,  0, 16'h0000, 8'h00, 0, 16'h0000, 16'h2000, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 1, 0, 8'h00, 0,  0, 16'h0000, 8'h00, 0, 16'h0000, 16'h2000, 0));
    tbl.push_back(mkv(L_IR, 1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 16'h2000, 8'h00, 0, 16'h0000, 16'h2000, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 16'h2000, 8'h00, 0, 16'h0000, 16'h2000, 0));
    tbl.push_back(mkv(0,    1, 1, 8'h70, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h70, 1, 16'h0000, 16'h2001, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h70, 0, 16'h0000, 16'h2001, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 1, 8'h23, 0,  0, 16'h0000, 8'h70, 0, 16'h0000, 16'h2301, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 1, 0, 8'hFF, 0,  0, 16'h0000, 8'h70, 0, 16'h0000, 16'h23FF, 0));
    tbl.push_back(mkv(L_IR, 1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 16'h23FF, 8'h70, 0, 16'h0000, 16'h23FF, 0));
    tbl.push_back(mkv(0,    1, 1, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h00, 1, 16'h0000, 16'h2000, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h00, 0, 16'h0000, 16'h2000, 0));
    tbl.push_back(mkv(L_IR, 1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 16'h2000, 8'h00, 0, 16'h0000, 16'h2000, 0));
    tbl.push_back(mkv(0,    1, 1, 8'h41, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h41, 1, 16'h0000, 16'h2001, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h41, 0, 16'h0000, 16'h2001, 0));
    tbl.push_back(mkv(L_JL, 1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 16'h2001, 8'h41, 0, 16'h0000, 16'h2001, 0));
    tbl.push_back(mkv(0,    1, 1, 8'h34, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h34, 1, 16'h0000, 16'h2002, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h34, 0, 16'h0000, 16'h2002, 0));
    tbl.push_back(mkv(L_JH, 1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 16'h2002, 8'h34, 0, 16'h0000, 16'h2002, 0));
    tbl.push_back(mkv(0,    1, 1, 8'h12, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h12, 1, 16'h0000, 16'h2003, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h12, 0, 16'h0000, 16'h2003, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 0, 8'h00, 1,  0, 16'h0000, 8'h12, 0, 16'h0000, 16'h1234, 0));
    tbl.push_back(mkv(L_IR, 1, 0, 8'h00, 0, 0, 8'h00, 1,  1, 16'h1234, 8'h12, 0, 16'h0000, 16'h1234, 0));
    tbl.push_back(mkv(0,    1, 1, 8'h00, 0, 0, 8'h00, 1,  0, 16'h0000, 8'h00, 1, 16'h0000, 16'h1235, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 0, 8'h00, 1,  0, 16'h0000, 8'h00, 0, 16'h0000, 16'h1235, 0));
    tbl.push_back(mkv(L_IR, 1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 16'h1235, 8'h00, 0, 16'h0000, 16'h1235, 0));
    tbl.push_back(mkv(0,    1, 1, 8'h42, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h42, 1, 16'h0000, 16'h1236, 0));
    tbl.push_back(mkv(L_ML, 1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h42, 0, 16'h0000, 16'h1236, 0));
    tbl.push_back(mkv(L_ML, 1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 16'h1236, 8'h42, 0, 16'h0000, 16'h1236, 0));
    tbl.push_back(mkv(0,    1, 1, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h00, 1, 16'h0000, 16'h1237, 0));
    tbl.push_back(mkv(L_MH, 1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h00, 0, 16'h0000, 16'h1237, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 16'h1237, 8'h00, 0, 16'h0000, 16'h1237, 0));
    tbl.push_back(mkv(0,    1, 1, 8'h40, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h40, 1, 16'h4000, 16'h1238, 0));
    tbl.push_back(mkv(0,    1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 8'h40, 0, 16'h4000, 16'h1238, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ld, tbl[i].dma, tbl[i].ack, tbl[i].dat,
            tbl[i].wrl, tbl[i].wrh, tbl[i].cd, tbl[i].jmp);
      tick();
      check_all($sformatf("row%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].eir,
                tbl[i].erdy, tbl[i].emsr, tbl[i].eptr, tbl[i].eovr);
    end

    // Three edges against a slow ack: one queued, one dropped.
    do_reset();
    drive(0, 1, 0, 0, 0, 1, 8'h30, 0); tick();
    req_rises = 0;
    drive(L_IR, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("ovr_req1", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h3000});
    drive(0, 1, 0, 0, 0, 0, 0, 0);    tick();
    drive(L_IR, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0);    tick();
    drive(L_IR, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("ovr_set", {30'd0, overrun, mem_req}, {30'd0, 1'b1, 1'b1});
    drive(0, 1, 0, 0, 0, 0, 0, 0);    tick();
    drive(0, 1, 1, 8'h11, 0, 0, 0, 0); tick();
    check_all("ovr_ack1", 0, 0, 8'h11, 1, 0, 16'h3001, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0);    tick();
    check_all("ovr_req2", 1, 16'h3001, 8'h11, 0, 0, 16'h3001, 1);
    drive(0, 1, 1, 8'h22, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("ovr_fetches", req_rises, 2);
    check_all("ovr_idle", 0, 0, 8'h22, 0, 0, 16'h3002, 1);

    // Trigger with DMA off stays pending until DMA is enabled.
    drive(L_IR, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("dma_off_noreq", {31'd0, mem_req}, 0);
    drive(L_IR, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("dma_on_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h3002});
    drive(L_IR, 1, 1, 8'h33, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();

    // Asynchronous reset in the middle of a request, then a late ack.
    drive(L_IR, 1, 0, 0, 0, 0, 0, 0); tick();
    chk("rst_pre_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h3003});
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 8'h55, 0, 0, 0, 0); tick();
    check_all("rst_hold", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_all("rst_late_ack", 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    // Jump target, CPU write priority over jump and ack, deferred jump.
    drive(L_JL, 1, 0, 0, 0, 0, 0, 0); tick();
    check_all("j_reqL", 1, 16'h0000, 0, 0, 0, 16'h0000, 0);
    drive(0, 1, 1, 8'h78, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(L_JH, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 8'h56, 0, 0, 0, 0); tick();
    check_all("j_ackH", 0, 0, 8'h56, 1, 0, 16'h0002, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 1, 0, 8'hCD, 1); tick();
    check_all("cpu_beats_jump", 0, 0, 8'h56, 0, 0, 16'h00CD, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 1); tick();
    check_all("jump_held_once", 0, 0, 8'h56, 0, 0, 16'h00CD, 0);
    drive(L_IR, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 8'h5A, 1, 0, 8'h10, 0); tick();
    check_all("cpu_beats_ack", 0, 0, 8'h5A, 1, 0, 16'h0010, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(L_IR, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 1); tick();
    check_all("jump_in_req", 1, 16'h0010, 8'h5A, 0, 0, 16'h0010, 0);
    drive(0, 1, 1, 8'h99, 0, 0, 0, 1); tick();
    check_all("jump_ack", 0, 0, 8'h99, 1, 0, 16'h0011, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 1); tick();
    check_all("jump_deferred", 0, 0, 8'h99, 0, 0, 16'h5678, 0);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] r_ld;
      int k;
      if (i % 1000 == 0) begin
        do_reset();
        r_ld = 0;
      end
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 4);
        r_ld[k] = ~r_ld[k];
      end
      drive(r_ld, ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < 40), 8'($urandom()),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0), 8'($urandom()),
            (($urandom_range(0, 9) == 0) ? ~d_jmp : d_jmp));
      model_step(d_ld, d_dma, d_ack, d_dat, d_wrl, d_wrh, d_cd, d_jmp);
      tick();
      check_all($sformatf("rand%0d", i), m_busy, m_busy ? m_ptr : 16'h0000, m_ir,
                m_rdy, m_msr, m_ptr, m_ovr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
